// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  localparam int unsigned DEF_REG_AW = 5;

endpackage

// File: rtl/pipe_fwd_unit.sv
// ALU operand-select comparator; only present when PIPE_FORWARD_EN is defined.
`ifdef PIPE_FORWARD_EN
module pipe_fwd_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = DEF_REG_AW
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  output logic [1:0]        sel
);

  // MEM holds the younger result, so it takes priority over WB.
  always_comb begin
    sel = FWD_RF;
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == rs))
      sel = FWD_MEM;
    else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs))
      sel = FWD_WB;
  end

endmodule
`endif

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/freeze sequencer for the 5-stage pipeline.
// Optional operand forwarding is enabled by defining PIPE_FORWARD_EN.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW      = DEF_REG_AW,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  input  logic              ex_branch_taken,
  input  logic              dmem_req,
  input  logic              dmem_ack,
  output logic              pc_we,
  output logic              ifid_we,
  output logic              idex_we,
  output logic              back_we,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              dmem_timeout,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              freeze;
  logic              ex_hit;
  logic              hazard;
  logic [1:0]        sel_a;
  logic [1:0]        sel_b;

  // An ack releases the pipe in the same cycle, including the last MEM_WAIT cycle.
  assign freeze = (state == ERR) || ((dmem_req || (state == MEM_WAIT)) && !dmem_ack);

  assign ex_hit = ex_reg_write && (ex_rd != '0) &&
                  ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

`ifdef PIPE_FORWARD_EN
  assign hazard = ex_hit && ex_mem_read;

  pipe_fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
    .rs            (ex_rs1),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .sel           (sel_a)
  );

  pipe_fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
    .rs            (ex_rs2),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .sel           (sel_b)
  );
`else
  logic mem_hit;
  logic unused_inputs;

  assign mem_hit = mem_reg_write && (mem_rd != '0) &&
                   ((id_use_rs1 && (id_rs1 == mem_rd)) || (id_use_rs2 && (id_rs2 == mem_rd)));
  assign hazard  = ex_hit || mem_hit;
  assign sel_a   = FWD_RF;
  assign sel_b   = FWD_RF;
  assign unused_inputs = ^{ex_mem_read, ex_rs1, ex_rs2, wb_rd, wb_reg_write};
`endif

  always_comb begin
    pc_we      = 1'b1;
    ifid_we    = 1'b1;
    idex_we    = 1'b1;
    back_we    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    fwd_a      = sel_a;
    fwd_b      = sel_b;
    if (!rst) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      idex_we    = 1'b0;
      back_we    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      fwd_a      = FWD_RF;
      fwd_b      = FWD_RF;
    end else if (freeze) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      idex_we = 1'b0;
      back_we = 1'b0;
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (hazard) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= RUN;
      wait_cnt     <= '0;
      stall_cnt    <= '0;
      dmem_timeout <= 1'b0;
    end else begin
      if (!pc_we && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      case (state)
        RUN: begin
          if (dmem_req && !dmem_ack) begin
            state    <= MEM_WAIT;
            wait_cnt <= WAIT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (dmem_ack) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
            state        <= ERR;
            dmem_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ERR:     dmem_timeout <= 1'b1;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed hazard scenarios followed by random traffic.
module tb_pipe_hazard_ctrl;

  localparam int unsigned AW  = 5;
  localparam int unsigned TMO = 16;

  typedef struct packed {
    logic          rst;
    logic [AW-1:0] id_rs1, id_rs2;
    logic          use1, use2;
    logic [AW-1:0] ex_rd;
    logic          ex_rw, ex_mr;
    logic [AW-1:0] ex_rs1, ex_rs2;
    logic [AW-1:0] mem_rd;
    logic          mem_rw;
    logic [AW-1:0] wb_rd;
    logic          wb_rw;
    logic          br, req, ack;
  } stim_t;

  typedef struct packed {
    logic [3:0]  we;
    logic [1:0]  fl;
    logic [1:0]  fa, fb;
    logic        tmo;
    logic [31:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [AW-1:0] id_rs1, id_rs2, ex_rd, ex_rs1, ex_rs2, mem_rd, wb_rd;
  logic          id_use_rs1, id_use_rs2, ex_reg_write, ex_mem_read;
  logic          mem_reg_write, wb_reg_write, ex_branch_taken, dmem_req, dmem_ack;
  logic          pc_we, ifid_we, idex_we, back_we, ifid_flush, idex_flush, dmem_timeout;
  logic [1:0]    fwd_a, fwd_b;
  logic [31:0]   stall_cnt;

  pipe_hazard_ctrl #(.REG_AW(AW), .MEM_TIMEOUT(TMO), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .ex_branch_taken(ex_branch_taken), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we), .back_we(back_we),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .dmem_timeout(dmem_timeout), .stall_cnt(stall_cnt)
  );

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  bit   done   = 1'b0;

  // Reference model state: sticky error, consecutive unacknowledged access cycles, stall tally.
  bit      m_err    = 1'b0;
  int      m_misses = 0;
  longint  m_cnt    = 0;

  function automatic bit reads(logic u, logic [AW-1:0] rs, logic [AW-1:0] rd);
    return u && (rd != 0) && (rs == rd);
  endfunction

  function automatic logic [1:0] fwd_sel(logic [AW-1:0] rs, stim_t s);
`ifdef PIPE_FORWARD_EN
    if (s.mem_rw && s.mem_rd != 0 && s.mem_rd == rs) return 2'b10;
    if (s.wb_rw && s.wb_rd != 0 && s.wb_rd == rs) return 2'b01;
`endif
    return 2'b00;
  endfunction

  function automatic stim_t idle();
    stim_t s = '0;
    s.rst = 1'b1;
    return s;
  endfunction

  task automatic run(input stim_t s);
    exp_t e;
    bit   outstanding, frozen, ex_dep, mem_dep, stall;
    @(posedge clk);
    #1;
    rst = s.rst; id_rs1 = s.id_rs1; id_rs2 = s.id_rs2; id_use_rs1 = s.use1; id_use_rs2 = s.use2;
    ex_rd = s.ex_rd; ex_reg_write = s.ex_rw; ex_mem_read = s.ex_mr; ex_rs1 = s.ex_rs1; ex_rs2 = s.ex_rs2;
    mem_rd = s.mem_rd; mem_reg_write = s.mem_rw; wb_rd = s.wb_rd; wb_reg_write = s.wb_rw;
    ex_branch_taken = s.br; dmem_req = s.req; dmem_ack = s.ack;

    outstanding = s.req || (m_misses > 0);
    frozen  = m_err || (outstanding && !s.ack);
    ex_dep  = s.ex_rw && (reads(s.use1, s.id_rs1, s.ex_rd) || reads(s.use2, s.id_rs2, s.ex_rd));
    mem_dep = s.mem_rw && (reads(s.use1, s.id_rs1, s.mem_rd) || reads(s.use2, s.id_rs2, s.mem_rd));
`ifdef PIPE_FORWARD_EN
    stall = ex_dep && s.ex_mr;
`else
    stall = ex_dep || mem_dep;
`endif
    e.fa  = fwd_sel(s.ex_rs1, s);
    e.fb  = fwd_sel(s.ex_rs2, s);
    e.tmo = m_err;
    e.cnt = 32'(m_cnt);
    if (!s.rst) begin
      e.we = 4'b0000; e.fl = 2'b11; e.fa = 2'b00; e.fb = 2'b00;
    end else if (frozen) begin
      e.we = 4'b0000; e.fl = 2'b00;
    end else if (s.br) begin
      e.we = 4'b1111; e.fl = 2'b11;
    end else if (stall) begin
      e.we = 4'b0011; e.fl = 2'b01;
    end else begin
      e.we = 4'b1111; e.fl = 2'b00;
    end
    q.push_back(e);

    if (!s.rst) begin
      m_err = 1'b0; m_misses = 0; m_cnt = 0;
    end else begin
      if (!e.we[3] && m_cnt < 64'hFFFF_FFFF) m_cnt++;
      if (!m_err) begin
        if (s.ack) m_misses = 0;
        else if (outstanding) begin
          m_misses++;
          if (m_misses > TMO) m_err = 1'b1;
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    int   idle_cycles = 0;
    int   guard = 0;
    forever begin
      @(negedge clk);
      guard++;
      if (q.size() > 0) begin
        e = q.pop_front();
        idle_cycles = 0;
        check("we",    32'({pc_we, ifid_we, idex_we, back_we}), 32'(e.we));
        check("flush", 32'({ifid_flush, idex_flush}), 32'(e.fl));
        check("fwd",   32'({fwd_a, fwd_b}), 32'({e.fa, e.fb}));
        check("tmo",   32'(dmem_timeout), 32'(e.tmo));
        check("cnt",   stall_cnt, e.cnt);
      end else if (done) begin
        break;
      end else begin
        idle_cycles++;
      end
      if (guard > 60000 || idle_cycles > 50) begin
        n_fail++;
        $display("FAIL watchdog: got %0d cycles expected completion", guard);
        break;
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin : driver
    stim_t s;
    int    ack_pct;
    rst = 1'b0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rd = '0; ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_rs1 = '0; ex_rs2 = '0;
    mem_rd = '0; mem_reg_write = 1'b0; wb_rd = '0; wb_reg_write = 1'b0;
    ex_branch_taken = 1'b0; dmem_req = 1'b0; dmem_ack = 1'b0;
    repeat (2) @(posedge clk);

    s = idle(); s.rst = 1'b0; run(s);
    run(idle());

    // load-use on rs1, then x0 (never a hazard), then load-use masked by a taken branch
    s = idle(); s.ex_mr = 1; s.ex_rw = 1; s.ex_rd = 5; s.id_rs1 = 5; s.use1 = 1; run(s);
    run(idle());
    s.ex_rd = 0; s.id_rs1 = 0; run(s);
    s = idle(); s.ex_mr = 1; s.ex_rw = 1; s.ex_rd = 5; s.id_rs1 = 5; s.use1 = 1; s.br = 1; run(s);
    s = idle(); s.ex_mr = 1; s.ex_rw = 1; s.ex_rd = 9; s.id_rs2 = 9; s.use2 = 1; run(s);

    // memory handshake acknowledged on the fourth cycle
    s = idle(); s.req = 1;
    repeat (3) run(s);
    s.ack = 1; run(s);
    run(idle());

    // ack arriving in the very last tolerated cycle wins over the timeout
    s = idle(); s.req = 1;
    repeat (TMO) run(s);
    s.ack = 1; run(s);
    run(idle());

    // no ack: error becomes sticky, then one reset edge clears it
    s = idle(); s.req = 1;
    repeat (TMO + 4) run(s);
    s = idle(); s.ack = 1; run(s);
    s = idle(); s.rst = 0; run(s);
    run(idle());

    // same register live in EX source, MEM and WB; ID also depends on the EX ALU result
    s = idle(); s.ex_rs1 = 7; s.mem_rd = 7; s.wb_rd = 7; s.mem_rw = 1; s.wb_rw = 1;
    s.ex_rd = 7; s.ex_rw = 1; s.id_rs1 = 7; s.use1 = 1; run(s);
    s = idle(); s.ex_rs2 = 3; s.wb_rd = 3; s.wb_rw = 1; s.mem_rd = 4; s.mem_rw = 1; run(s);

    for (int blk = 0; blk < 30; blk++) begin
      ack_pct = (blk % 5 == 4) ? 2 : 40;
      for (int i = 0; i < 100; i++) begin
        s = idle();
        s.rst    = ($urandom_range(0, 149) != 0);
        s.id_rs1 = AW'($urandom_range(0, 3));
        s.id_rs2 = AW'($urandom_range(0, 3));
        s.use1   = 1'($urandom);
        s.use2   = 1'($urandom);
        s.ex_rd  = AW'($urandom_range(0, 3));
        s.ex_rw  = 1'($urandom);
        s.ex_mr  = 1'($urandom);
        s.ex_rs1 = AW'($urandom_range(0, 3));
        s.ex_rs2 = AW'($urandom_range(0, 3));
        s.mem_rd = AW'($urandom_range(0, 3));
        s.mem_rw = 1'($urandom);
        s.wb_rd  = AW'($urandom_range(0, 3));
        s.wb_rw  = 1'($urandom);
        s.br     = ($urandom_range(0, 99) < 15);
        s.req    = ($urandom_range(0, 99) < 20);
        s.ack    = ($urandom_range(0, 99) < ack_pct);
        run(s);
      end
    end
    done = 1'b1;
  end

endmodule
